// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file with one synchronous write port, two
//   combinational read ports and an optional hardwired-zero register 0.
//   A clear sequencer zeroes every register, one per cycle, after reset
//   or on clr_req. Reads return 0 and writes are dropped while it runs.
//
// Optional feature macro: REGFILE_WRITE_BYPASS_EN
//   defined   : a write accepted this cycle is forwarded to any read port
//               addressing the same register (same-cycle visibility)
//   undefined : read-during-write returns the old value
//
// Parameters: DATA_W (register width), ADDR_W (DEPTH = 2**ADDR_W),
//             ZERO_REG (1 = register 0 reads 0 and ignores writes)
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset, restarts the clear
//   clr_req  in   one-cycle clear request (honoured only in RUN)
//   we3      in   write enable
//   wa3      in   write address   [ADDR_W]
//   wd3      in   write data      [DATA_W]
//   ra1/ra2  in   read addresses  [ADDR_W]
//   rd1/rd2  out  read data       [DATA_W], combinational
//   busy     out  clear sequencer running
//
// state   | meaning
// --------+-----------------------------------------------
// S_CLEAR | writing 0 to rf[clr_idx], one register per cycle
// S_RUN   | normal read/write operation
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // One extra index bit so the last register is reached without wrapping.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W + 1)'(1);

  logic [0:0]        r_state;
  logic [ADDR_W:0]   r_clr_idx;
  logic [DATA_W-1:0] r_rf [DEPTH];

  logic w_run;
  logic w_clear_wr;
  logic w_user_wr;

  assign w_run      = (r_state == S_RUN);
  assign w_clear_wr = !reset && !w_run;
  // A clear request wins over a write presented in the same cycle.
  assign w_user_wr  = !reset && w_run && !clr_req && we3 && !(ZR && (wa3 == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_idx <= r_clr_idx + IDX_ONE;
          if (r_clr_idx == LAST_IDX) r_state <= S_RUN;
        end
        S_RUN: begin
          if (clr_req) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
          end
        end
        default: begin
          r_state   <= S_CLEAR;
          r_clr_idx <= '0;
        end
      endcase
    end
  end

  // Storage has no reset of its own; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (w_clear_wr) begin
      r_rf[r_clr_idx[ADDR_W-1:0]] <= '0;
    end else if (w_user_wr) begin
      r_rf[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = r_rf[ra1];
    rd2 = r_rf[ra2];
`ifdef REGFILE_WRITE_BYPASS_EN
    // w_user_wr already excludes clear, reset and the zero register.
    if (w_user_wr && (wa3 == ra1)) rd1 = wd3;
    if (w_user_wr && (wa3 == ra2)) rd2 = wd3;
`endif
    if (reset || !w_run || (ZR && (ra1 == '0))) rd1 = '0;
    if (reset || !w_run || (ZR && (ra2 == '0))) rd2 = '0;
  end

  assign busy = !w_run;

endmodule
